// File: rtl/card_ram_arbiter_pkg.sv
// Shared constants, card word layout and FSM encoding for the card RAM arbiter.
package card_ram_arbiter_pkg;

    localparam int CARD_ADDR_W = 10;
    localparam int CARD_DATA_W = 32;

    // Card word field positions.
    localparam int CARD_USED_BIT = 31;
    localparam int CARD_SUIT_HI  = 21;
    localparam int CARD_SUIT_LO  = 20;
    localparam int CARD_VALUE_HI = 19;
    localparam int CARD_VALUE_LO = 16;
    localparam int CARD_NEXT_HI  = 9;
    localparam int CARD_NEXT_LO  = 0;

    // A NEXT field of zero terminates a card list.
    localparam logic [CARD_DATA_W-1:0] NULL_CARD = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       used;
        logic [8:0] rsvd_hi;
        logic [1:0] suit;
        logic [3:0] value;
        logic [5:0] rsvd_lo;
        logic [9:0] next;
    } card_word_t;

    // Width of an index into n requesters; never zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Assemble a card word from its fields; reserved bits are zero.
    function automatic logic [CARD_DATA_W-1:0] make_card(
        input logic       used,
        input logic [1:0] suit,
        input logic [3:0] value,
        input logic [9:0] next
    );
        card_word_t w;
        w       = '0;
        w.used  = used;
        w.suit  = suit;
        w.value = value;
        w.next  = next;
        return w;
    endfunction

endpackage

// File: rtl/card_ram_arbiter_if.sv
// Requester bus plus card RAM port bundle for the card RAM arbiter.
// master = requesters and RAM (environment), slave = arbiter.
interface card_ram_arbiter_if
    import card_ram_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = CARD_ADDR_W,
    parameter int DATA_W = CARD_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic [ADDR_W-1:0]       ram_address;
    logic [DATA_W-1:0]       ram_data;
    logic                    ram_wren;
    logic [DATA_W-1:0]       ram_q;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata, ram_q,
        input  gnt, rsp_valid, rsp_rdata, ram_address, ram_data, ram_wren
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, ram_q,
        output gnt, rsp_valid, rsp_rdata, ram_address, ram_data, ram_wren
    );

endinterface

// File: rtl/card_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requesting index above the
// pointer wins, wrapping from N_REQ-1 back to 0.
module card_ram_arbiter_rr_arbiter
    import card_ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    int cand;

    // Scan pointer+1 .. pointer+N_REQ (mod N_REQ) and keep the first hit.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(pointer) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/card_ram_arbiter.sv
// Shares one ram1024x32 card memory between N_REQ requesters.
// One access in flight: IDLE (arbitrate, drive RAM inputs) -> ACCESS (RAM
// samples) -> RESP (capture q, acknowledge owner). All outputs registered.
module card_ram_arbiter
    import card_ram_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = CARD_ADDR_W,
    parameter int DATA_W = CARD_DATA_W
) (
    input  logic            clock,
    input  logic            reset,
    card_ram_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;

    logic [N_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]  rr_index;
    logic              rr_valid;

    logic              lock_hit;
    logic [N_REQ-1:0]  owner_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_onehot;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_we;

    card_ram_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (bus.req),
        .pointer (ptr_q),
        .grant   (rr_grant),
        .index   (rr_index),
        .valid   (rr_valid)
    );

    // A locked owner that is still requesting keeps the RAM; otherwise round-robin.
    assign lock_hit     = bus.req_lock[owner_q] & bus.req[owner_q];
    assign owner_onehot = N_REQ'(1) << owner_q;
    assign win_idx      = lock_hit ? owner_q : rr_index;
    assign win_onehot   = lock_hit ? owner_onehot : rr_grant;
    assign win_addr     = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data     = bus.req_wdata[win_idx*DATA_W +: DATA_W];
    assign win_we       = bus.req_we[win_idx];

    // Next-state and next-output logic; pulses default low, datapath holds.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    addr_d  = win_addr;
                    data_d  = win_data;
                    wren_d  = win_we;
                    gnt_d   = win_onehot;
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // RAM samples address/data/wren at the end of this cycle.
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_rdata_d = bus.ram_q;
                rsp_valid_d = owner_onehot;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.ram_wren    = wren_q;

endmodule
